// File: rtl/expr_pipe_acc.sv
// Three-stage valid/ready pipeline evaluating the SEED-mixing expression on a stream,
// with per-item mode selecting constant, plain, accumulate or folded output.
module expr_pipe_acc #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 19,
  parameter int unsigned SEED  = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   input_data,
  input  logic [1:0]        mode,
  input  logic              acc_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  output_data,
  output logic [15:0]       count,
  output logic              busy
);

  localparam int unsigned     CNT_W      = 16;
  localparam logic [OUT_W-1:0] SEED_W    = OUT_W'(SEED);
  localparam logic [1:0]      MODE_CONST = 2'd0;
  localparam logic [1:0]      MODE_PLAIN = 2'd1;
  localparam logic [1:0]      MODE_ACC   = 2'd2;
  localparam logic [1:0]      MODE_FOLD  = 2'd3;

  logic              adv;
  logic [OUT_W-1:0]  x_ext;
  logic [OUT_W-1:0]  a_c;
  logic [OUT_W-1:0]  b_c;
  logic [OUT_W-1:0]  acc_base_c;
  logic [OUT_W-1:0]  sum_c;
  logic [OUT_W-1:0]  res_c;
  logic              acc_load_c;

  logic              s1_v;
  logic [OUT_W-1:0]  s1_a;
  logic [OUT_W-1:0]  s1_x;
  logic [1:0]        s1_mode;
  logic              s2_v;
  logic [OUT_W-1:0]  s2_b;
  logic [1:0]        s2_mode;
  logic [OUT_W-1:0]  acc;

  // Whole pipe stalls only when a held result is not being taken.
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;
  assign busy     = s1_v | s2_v | out_valid;

  assign x_ext = OUT_W'(input_data);
  assign a_c   = ((SEED_W & x_ext) ^ SEED_W) | x_ext;
  assign b_c   = s1_a * SEED_W + s1_a - s1_x;

  // A clear in the same cycle as an accumulate load discards the old total.
  assign acc_base_c = acc_clr ? '0 : acc;
  assign sum_c      = acc_base_c + s2_b;
  assign acc_load_c = adv && s2_v && (s2_mode == MODE_ACC);

  always_comb begin
    res_c = s2_b;
    case (s2_mode)
      MODE_CONST: res_c = SEED_W;
      MODE_PLAIN: res_c = s2_b;
      MODE_ACC:   res_c = sum_c;
      MODE_FOLD:  res_c = s2_b ^ (s2_b >> 3);
      default:    res_c = s2_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v        <= 1'b0;
      s1_a        <= '0;
      s1_x        <= '0;
      s1_mode     <= MODE_CONST;
      s2_v        <= 1'b0;
      s2_b        <= '0;
      s2_mode     <= MODE_CONST;
      out_valid   <= 1'b0;
      output_data <= '0;
      acc         <= '0;
      count       <= '0;
    end else begin
      if (adv) begin
        s1_v    <= in_valid;
        s1_a    <= a_c;
        s1_x    <= x_ext;
        s1_mode <= mode;
        s2_v    <= s1_v;
        s2_b    <= b_c;
        s2_mode <= s1_mode;
        out_valid <= s2_v;
        if (s2_v) output_data <= res_c;
      end
      if (acc_load_c) acc <= sum_c;
      else if (acc_clr) acc <= '0;
      if (out_valid && out_ready && (count != {CNT_W{1'b1}}))
        count <= count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_expr_pipe_acc.sv
// Randomized and directed bench for expr_pipe_acc against an arithmetic reference model.
module tb_expr_pipe_acc;

  localparam int unsigned IN_W  = 4;
  localparam int unsigned OUT_W = 19;
  localparam int unsigned SEED  = 13;
  localparam longint      MASK  = (64'd1 << OUT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   input_data;
  logic [1:0]        mode;
  logic              acc_clr;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  output_data;
  logic [15:0]       count;
  logic              busy;

  logic              in_ready8;
  logic              out_valid8;
  logic [7:0]        output_data8;
  logic [15:0]       count8;
  logic              busy8;

  always #5 clk = ~clk;

  expr_pipe_acc #(.IN_W(IN_W), .OUT_W(OUT_W), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .input_data(input_data), .mode(mode), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .output_data(output_data),
    .count(count), .busy(busy)
  );

  expr_pipe_acc #(.IN_W(IN_W), .OUT_W(8), .SEED(SEED)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .input_data(input_data), .mode(mode), .acc_clr(acc_clr),
    .out_valid(out_valid8), .out_ready(out_ready), .output_data(output_data8),
    .count(count8), .busy(busy8)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit sb_en    = 1'b0;
  int n_out    = 0;
  longint model_acc = 0;
  longint exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: expression evaluated with plain integer arithmetic.
  function automatic longint ref_b(input longint x);
    longint a;
    a = ((SEED & x) ^ SEED) | x;
    return (a * SEED + a - x) & MASK;
  endfunction

  function automatic longint model_out(input longint x, input int m);
    longint b;
    b = ref_b(x);
    case (m)
      0: return SEED;
      1: return b;
      2: begin model_acc = (model_acc + b) & MASK; return model_acc; end
      default: return b ^ (b >> 3);
    endcase
  endfunction

  // One clock: record handshakes seen before the edge, then sample 1ns after it.
  task automatic tick();
    bit acc_hs, out_hs;
    acc_hs = in_valid && in_ready;
    out_hs = out_valid && out_ready;
    if (sb_en && out_hs) begin
      n_out++;
      if (exp_q.size() == 0) check("sb_unexpected_output", 64'(output_data), 64'hDEAD);
      else check("sb_data", 64'(output_data), 64'(exp_q.pop_front()));
    end
    if (sb_en && acc_hs) exp_q.push_back(model_out(longint'(input_data), int'(mode)));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    model_acc = 0;
  endtask

  // Single item, output expected on the third edge counting the accept edge.
  task automatic send_one(input int x, input int m, input longint exp);
    in_valid = 1'b1; input_data = IN_W'(x); mode = 2'(m);
    tick();
    in_valid = 1'b0;
    check("lat_edge1_valid", 64'(out_valid), 64'd0);
    tick();
    check("lat_edge2_valid", 64'(out_valid), 64'd0);
    tick();
    check("lat_edge3_valid", 64'(out_valid), 64'd1);
    check("lat_edge3_data", 64'(output_data), 64'(exp));
    tick();
  endtask

  task automatic run_stream(input int n_items, input bit rand_valid, input bit rand_ready,
                            input bit bp_test);
    int sent = 0;
    int cyc = 0;
    int stall = -1;
    bit accept;
    logic [OUT_W-1:0] held = '0;
    sb_en = 1'b1;
    n_out = 0;
    while ((sent < n_items || exp_q.size() > 0 || out_valid) && cyc < 5000) begin
      if (!in_valid && sent < n_items && (!rand_valid || $urandom_range(3) != 0)) begin
        in_valid   = 1'b1;
        input_data = IN_W'($urandom);
        mode       = bp_test ? 2'd1 : 2'($urandom);
      end
      if (bp_test) begin
        if (stall < 0 && out_valid) stall = cyc;
        out_ready = !(stall >= 0 && cyc < stall + 4);
      end else if (rand_ready) begin
        out_ready = ($urandom_range(3) != 0);
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (bp_test && stall >= 0 && cyc < stall + 4) begin
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        if (cyc == stall) held = output_data;
        else check("bp_data_stable", 64'(output_data), 64'(held));
      end
      accept = in_valid && in_ready;
      tick();
      if (accept) begin
        in_valid = 1'b0;
        sent++;
      end
      cyc++;
    end
    if (cyc >= 5000) check("stream_timeout", 64'(cyc), 64'd0);
    check("stream_out_count", 64'(n_out), 64'(n_items));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sb_en     = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; input_data = '0; mode = 2'd0;
    acc_clr = 1'b0; out_ready = 1'b1;
    tick();
    do_reset();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_output_data", 64'(output_data), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    send_one(5, 1, 177);
    check("count_after_one", 64'(count), 64'd1);
    send_one(5, 3, 167);
    send_one(9, 0, 13);
    send_one(0, 0, 13);

    // Back-to-back accumulate, both widths in lockstep.
    do_reset();
    in_valid = 1'b1; input_data = '0; mode = 2'd2;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    check("acc1_valid", 64'(out_valid), 64'd1);
    check("acc1_data", 64'(output_data), 64'd182);
    check("acc1_data_w8", 64'(output_data8), 64'd182);
    tick();
    check("acc2_valid", 64'(out_valid), 64'd1);
    check("acc2_data", 64'(output_data), 64'd364);
    check("acc2_data_w8", 64'(output_data8), 64'd108);
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    check("clr_load_valid", 64'(out_valid), 64'd1);
    check("clr_load_data", 64'(output_data), 64'd182);
    tick();
    send_one(0, 2, 364);

    // Reset with items in flight.
    do_reset();
    in_valid = 1'b1; mode = 2'd2;
    for (int i = 0; i < 3; i++) begin
      input_data = IN_W'($urandom);
      tick();
    end
    in_valid = 1'b0;
    do_reset();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_count", 64'(count), 64'd0);
    send_one(0, 2, 182);

    // Backpressure stall on a 5-item burst.
    do_reset();
    run_stream(5, 1'b0, 1'b0, 1'b1);
    check("bp_count", 64'(count), 64'd5);

    // Random valid/ready traffic over all modes.
    do_reset();
    run_stream(300, 1'b1, 1'b1, 1'b0);
    check("rand_count", 64'(count), 64'd300);
    check("rand_idle_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
